// File: rtl/piezo_sound_arbiter_if.sv
// piezo_sound_arbiter_if: note-event request bus between sound sources and the piezo arbiter
interface piezo_sound_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DUR_W   = 32
);
   localparam int OW = $clog2(NUM_REQ);
   logic [NUM_REQ-1:0]       req_valid;
   logic [4*NUM_REQ-1:0]     req_note;
   logic [DUR_W*NUM_REQ-1:0] req_dur;
   logic [NUM_REQ-1:0]       req_ready;
   logic                     mute;
   logic [3:0]               note_out;
   logic                     note_active;
   logic [OW-1:0]            owner;
   logic [NUM_REQ-1:0]       done;
   logic                     aborted;
   logic                     busy;
   modport master (
      output req_valid, req_note, req_dur, mute,
      input  req_ready, note_out, note_active, owner, done, aborted, busy
   );
   modport slave (
      input  req_valid, req_note, req_dur, mute,
      output req_ready, note_out, note_active, owner, done, aborted, busy
   );
endinterface

// File: rtl/piezo_sound_arbiter.sv
// piezo_sound_arbiter: priority/preemptive scheduler of note events onto one piezo tone generator; PIEZO_ARB_RR_EN adds round-robin among requesters 1..NUM_REQ-1
module piezo_sound_arbiter #(
   parameter int                 NUM_REQ      = 4,
   parameter int                 DUR_W        = 32,
   parameter int                 GAP_CYC      = 1000,
   parameter logic [NUM_REQ-1:0] PREEMPT_MASK = NUM_REQ'(1)
) (
   input logic clk,
   input logic reset_n,
   piezo_sound_arbiter_if.slave bus
);
   localparam int OW = $clog2(NUM_REQ);
   localparam logic [DUR_W-1:0] GAP_LD = DUR_W'(GAP_CYC > 0 ? GAP_CYC - 1 : 0);
   typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
   state_t             state, state_d;
   logic [DUR_W-1:0]   counter, dur_sel;
   logic [3:0]         note_r;
   logic               mute_q;
   logic [OW-1:0]      owner_r, win, pre_idx, gnt_idx;
   logic               pre_hit, gnt_any;
   logic [NUM_REQ-1:0] done_r;
   logic               aborted_r;
`ifdef PIEZO_ARB_RR_EN
   logic [OW-1:0]      ptr, rr_idx;
`endif
   // state register
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_d;
   // grant selection and next state; a preemption on the owner's final cycle is ignored so the note completes
   always_comb begin
      win = '0;
`ifdef PIEZO_ARB_RR_EN
      rr_idx = '0;
      for (int i = NUM_REQ - 2; i >= 0; i--) begin
         rr_idx = OW'((int'(ptr) - 1 + i) % (NUM_REQ - 1) + 1);
         if (bus.req_valid[rr_idx]) win = rr_idx;
      end
      if (bus.req_valid[0]) win = '0;
`else
      for (int i = NUM_REQ - 1; i >= 0; i--)
         if (bus.req_valid[i]) win = OW'(i);
`endif
      pre_hit = 1'b0;
      pre_idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--)
         if (i < int'(owner_r) && bus.req_valid[i] && PREEMPT_MASK[i]) begin
            pre_hit = 1'b1;
            pre_idx = OW'(i);
         end
      state_d = state;
      gnt_any = 1'b0;
      gnt_idx = win;
      case (state)
         IDLE: begin
            gnt_any = |bus.req_valid;
            state_d = gnt_any ? PLAY : IDLE;
         end
         PLAY:
            if (counter == '0) state_d = (GAP_CYC > 0) ? GAP : IDLE;
            else begin
               gnt_any = pre_hit;
               gnt_idx = pre_idx;
            end
         default: state_d = (counter == '0) ? IDLE : GAP;
      endcase
      dur_sel = bus.req_dur[DUR_W*gnt_idx +: DUR_W];
   end
   // note latch, shared play/gap down-counter, done/aborted pulses and mute pipeline
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         counter   <= '0;
         note_r    <= 4'hF;
         mute_q    <= 1'b0;
         owner_r   <= '0;
         done_r    <= '0;
         aborted_r <= 1'b0;
`ifdef PIEZO_ARB_RR_EN
         ptr       <= OW'(1);
`endif
      end else begin
         mute_q    <= bus.mute;
         done_r    <= '0;
         aborted_r <= 1'b0;
         if (gnt_any) begin
            owner_r <= gnt_idx;
            note_r  <= bus.req_note[4*gnt_idx +: 4];
            counter <= (dur_sel == '0) ? '0 : dur_sel - DUR_W'(1);
            if (state == PLAY) begin
               done_r    <= NUM_REQ'(1) << owner_r;
               aborted_r <= 1'b1;
            end
         end else if (state == PLAY && counter == '0) begin
            done_r  <= NUM_REQ'(1) << owner_r;
            counter <= GAP_LD;
         end else if (counter != '0) counter <= counter - DUR_W'(1);
`ifdef PIEZO_ARB_RR_EN
         if (gnt_any && gnt_idx != '0) ptr <= (gnt_idx == OW'(NUM_REQ - 1)) ? OW'(1) : gnt_idx + OW'(1);
`endif
      end
   // outputs; req_ready is held low while reset is asserted
   always_comb begin
      bus.req_ready   = (gnt_any && reset_n) ? NUM_REQ'(1) << gnt_idx : '0;
      bus.note_out    = (state == PLAY && !mute_q) ? note_r : 4'hF;
      bus.note_active = state == PLAY;
      bus.busy        = state != IDLE;
      bus.owner       = owner_r;
      bus.done        = done_r;
      bus.aborted     = aborted_r;
   end
endmodule

// File: doc/piezo_sound_arbiter.md
Name: piezo_sound_arbiter

Overview:
- Schedules the single piezo tone generator among NUM_REQ sound sources, e.g. countdown beep, win/lose jingle and background music.
- Each source submits one note event at a time: a note code plus a duration in clock cycles.
- Grants by priority, with optional preemption. Times each note and drives the note select that feeds the tone/period datapath.
- Returns a per-source done/aborted pulse so sources can sequence their melodies.

Parameters:
- NUM_REQ, 4: number of requesters. Index 0 is highest priority.
- DUR_W, 32: width of the duration field and duration counter.
- GAP_CYC, 1000: silent cycles inserted after each completed note. Range 0..65535.
- PREEMPT_MASK, 4'b0001: bit i=1 lets requester i preempt a lower-priority owner.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-source note event valid
- req_note  in  4*NUM_REQ  note code, slice i = [4i+3:4i]; 15 = rest (NONE)
- req_dur  in  DUR_W*NUM_REQ  note length in cycles, slice i
- req_ready  out  NUM_REQ  one-hot accept strobe, combinational
- mute  in  1  level; silences output without altering timing
- note_out  out  4  note code to tone generator; 15 = silent
- note_active  out  1  a note event (including a rest) is in progress
- owner  out  $clog2(NUM_REQ)  index of current/last granted source
- done  out  NUM_REQ  one-cycle pulse to the owner when its event ends
- aborted  out  1  qualifies done: 1 = ended by preemption
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, note_out=15, note_active=0, owner=0, done=0, aborted=0, busy=0, counter=0.
  - req_ready is 0 while in reset.
  - Reset mid-note abandons the event; no done pulse is issued.
- States: IDLE, PLAY, GAP.
- Grant, IDLE state:
  - The lowest index with req_valid=1 wins; req_ready[win]=1 that cycle.
  - The arbiter latches note and duration; dur=0 is treated as 1.
  - Next cycle: state=PLAY, owner=win, note_active=1, note_out=latched note (15 if mute).
- PLAY state:
  - The note is held for exactly dur cycles. The counter loads dur-1 and decrements each cycle.
  - On the cycle the counter is 0: done[owner]=1 and aborted=0 are driven on the next edge, as a registered pulse.
  - Then the arbiter goes to GAP if GAP_CYC>0, otherwise to IDLE. note_active=0 and note_out=15 from that edge.
- GAP state:
  - note_out=15 for exactly GAP_CYC cycles, then IDLE. No grants are made in GAP.
- Back-to-back notes:
  - Minimum silence between two notes is GAP_CYC+1 cycles, including the IDLE grant cycle.
  - With GAP_CYC=0 the minimum is 1 cycle.
- Preemption, PLAY state:
  - Triggered when some j<owner has req_valid[j]=1 and PREEMPT_MASK[j]=1. The lowest such j wins.
  - req_ready[j]=1 that cycle. done[owner]=1 and aborted=1 are registered.
  - j's note starts on the next cycle with no gap; owner=j.
  - Equal- or lower-priority requests wait.
  - No preemption during GAP or IDLE; the normal grant applies.
- Simultaneous events:
  - Preemption request on the owner's final cycle: the current note completes normally (aborted=0), and the request is served via IDLE.
  - Multiple valids: only one req_ready is asserted per cycle.
- Handshake: a source must hold req_valid/note/dur stable until req_ready. It may present its next event in the cycle after done.
- Mute:
  - Affects only note_out, forcing it to 15.
  - Counters, done, grants and note_active are unaffected.
  - Toggling mid-note takes effect on the next cycle.
- Rest: note=15 plays silence for dur cycles with note_active=1 and completes like any note.
- Out-of-range owner: not possible by construction. done is always one-hot or zero.

Optional Feature:
- Macro: PIEZO_ARB_RR_EN.
- When defined, requesters 1..NUM_REQ-1 share round-robin priority:
  - A rotating pointer starts at 1 after reset.
  - After each grant to k≥1, the pointer advances to the next index after k, wrapping 1..NUM_REQ-1.
  - Requester 0 stays strictly highest.
  - Preemption eligibility still uses index order and PREEMPT_MASK.
- When undefined: pure fixed priority (lowest index wins) and no pointer logic.

Test Plan:
- GAP_CYC=4, req_valid[2]=1, note=9, dur=10 → req_ready[2] for 1 cycle; note_out=9 for exactly 10 cycles; done[2] pulse with aborted=0; then note_out=15 for 4 cycles; busy=0.
- Owner 3 playing note 11 for dur=100; at cycle 20 req_valid[0]=1 with note 15, dur=5 → done[3] pulse with aborted=1; the next cycle note_active=1, note_out=15 for 5 cycles, owner=0. Then done[0] with aborted=0.
- req_valid[1] and req_valid[2] both asserted in IDLE → [1] granted first, [2] granted after [1]'s note and gap. With PIEZO_ARB_RR_EN and continuous requests on 1 and 2, grants alternate 1,2,1,2.
- dur=0 → the note lasts exactly 1 cycle and done fires. A preemption request arriving on the owner's final cycle → aborted=0, and the new grant comes from IDLE.
- mute=1 during a 50-cycle note → note_out=15 but done still occurs at cycle 50. mute=0 at cycle 30 → note_out restored at cycle 31.
- reset_n=0 mid-PLAY → all outputs return to their reset values asynchronously and no done pulse occurs. After reset_n=1 a new request is granted normally.
